rv32i_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the RV32IM pipeline.
- Owns the PC and issues addresses to rv32i_inst_mem, which has a synchronous 1-cycle read.
- Buffers returned instructions in a 2-entry skid buffer and presents them to rv32i_decoder through a valid/stall handshake.
- Handles redirects (branch/jump/flush) from EX by dropping stale fetches.

---
 rtl/rv32i_fetch_pkg.sv | 28 ++
 rtl/rv32i_fetch_skid.sv | 77 +++++++
 rtl/rv32i_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_rv32i_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch sequencer.
package rv32i_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;          // holds 0..SKID_DEPTH
  localparam int unsigned OCC_W      = CNT_W + 1;  // occupancy incl. in-flight fetch
  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned PERF_CNT_W = 32;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  // FSM encoding kept as plain constants for legacy tools
  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t S_RESET = 1'b0;
  localparam fetch_state_t S_RUN   = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Force an address onto a 4-byte boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/rv32i_fetch_skid.sv
// Two-entry skid FIFO for fetched instructions. Slot 0 is always the head and
// doubles as the registered output; when empty its inst reads as NOP and its
// pc keeps the last presented value.
module rv32i_fetch_skid
  import rv32i_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output fetch_entry_t     head
);

  fetch_entry_t     slot0_q, slot0_d;
  fetch_entry_t     slot1_q, slot1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             do_pop;

  // Next-state: flush dominates, then shift-on-pop with optional refill
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop & (count_q != '0);
    if (flush) begin
      count_d      = '0;
      slot0_d.inst = INST_NOP;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
      if (do_pop) begin
        if (count_q == CNT_W'(SKID_DEPTH)) begin
          slot0_d = slot1_q;
          if (push) slot1_d = push_data;
        end else if (push) begin
          slot0_d = push_data;
        end else begin
          slot0_d.inst = INST_NOP;
        end
      end else if (push) begin
        if (count_q == '0) slot0_d = push_data;
        else               slot1_d = push_data;
      end
    end
    valid_d = (count_d != '0);
  end

  // Storage and registered status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0_q <= '{inst: INST_NOP, pc: '0};
      slot1_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign count = count_q;
  assign valid = valid_q;
  assign head  = slot0_q;

`ifndef SYNTHESIS
  // The upstream issue throttle must keep responses out of a full buffer
  assert property (@(posedge clk) disable iff (!rst)
    !(push && !flush && (count_q == CNT_W'(SKID_DEPTH))));
`endif

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// RV32I instruction-fetch sequencer: owns the PC, issues requests to a
// 1-cycle synchronous instruction memory, buffers responses in a skid FIFO
// and drops stale fetches on redirect.
// Optional perf counters (o_fetch_cnt, o_flush_cnt) under RV32I_FETCH_PERF_EN.
module rv32i_fetch_ctrl
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] o_imem_addr,
  output logic             o_imem_req,
  input  logic [WIDTH-1:0] i_imem_inst,
  output logic [WIDTH-1:0] o_inst,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_valid,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc
`ifdef RV32I_FETCH_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] o_fetch_cnt,
  output logic [PERF_CNT_W-1:0] o_flush_cnt
`endif
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             f_q, f_d;

  logic [CNT_W-1:0] skid_count;
  logic             skid_valid;
  fetch_entry_t     skid_head;
  fetch_entry_t     push_data;
  logic             pop, push, issue;
  logic [OCC_W-1:0] occupancy;

  // FSM next state: a single idle cycle after reset, then run forever
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Issue throttle, PC sequencing and redirect handling
  always_comb begin
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    f_d       = 1'b0;
    pop       = skid_valid & ~i_stall;
    push      = f_q & ~i_redirect;
    // Entries held plus the one in flight, after this cycle's pop
    occupancy = OCC_W'(skid_count) + OCC_W'(f_q) - OCC_W'(pop);
    issue     = (state_q == S_RUN) & ~i_redirect & (occupancy < OCC_W'(SKID_DEPTH));
    if (i_redirect) begin
      pc_d = word_align(i_redirect_pc);
    end else if (issue) begin
      pc_d     = pc_q + WIDTH'(PC_STEP);
      req_pc_d = pc_q;
      f_d      = 1'b1;
    end
    push_data = '{inst: i_imem_inst, pc: req_pc_q};
  end

  // State, PC and in-flight tracking registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RESET;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      f_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      f_q      <= f_d;
    end
  end

  rv32i_fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (i_redirect),
    .count     (skid_count),
    .valid     (skid_valid),
    .head      (skid_head)
  );

  assign o_imem_addr = pc_q;
  assign o_imem_req  = issue;
  assign o_inst      = skid_head.inst;
  assign o_pc        = skid_head.pc;
  assign o_valid     = skid_valid;

`ifdef RV32I_FETCH_PERF_EN
  logic [PERF_CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Free-running wrap-around event counters
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + PERF_CNT_W'(issue);
    flush_cnt_d = flush_cnt_q + PERF_CNT_W'(i_redirect & (state_q == S_RUN));
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Bench for rv32i_fetch_ctrl: directed cycle table, async reset checks and a
// randomized run against a stream-level reference model.
module tb_rv32i_fetch_ctrl;
  import rv32i_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_inst = 32'h0;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef RV32I_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  rv32i_fetch_ctrl #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .o_imem_addr   (imem_addr),
    .o_imem_req    (imem_req),
    .i_imem_inst   (imem_inst),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_valid       (o_valid),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc)
`ifdef RV32I_FETCH_PERF_EN
    ,
    .o_fetch_cnt   (fetch_cnt),
    .o_flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Program image: two real instructions at 0/4, address-tagged words elsewhere
  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Synchronous 1-cycle read memory
  always @(posedge clk) begin
    if (imem_req) imem_inst <= memw(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [19];

  // Async reset asserted mid-cycle: outputs must clear without a clock edge
  task automatic async_reset_check();
    #3 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_inst", o_inst, INST_NOP);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    stall    = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Reference: the decoder must see the program stream in order from the last
  // redirect target, with the fixed fill latency and a 2-deep fetch window.
  task automatic run_model(input int n, input logic rd0, input logic [31:0] rp0);
    logic [31:0] exp_pc    = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;
    int          out       = 0;
    int          ev        = 0;
    logic        in_run    = 1'b0;
    logic        st, rd, pop, exp_req;
    logic [31:0] rp;
`ifdef RV32I_FETCH_PERF_EN
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_flush = 32'h0;
`endif
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) rst = 1'b1;
      if (k == 0) begin
        st = 1'b0; rd = rd0; rp = rp0;
      end else if (k < 4) begin
        st = 1'b0; rd = 1'b0; rp = 32'h0;
      end else begin
        st = ($urandom_range(0, 99) < 30);
        rd = ($urandom_range(0, 99) < 6);
        if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else                           rp = 32'($urandom_range(0, 1023));
      end
      stall = st; redirect = rd; redirect_pc = rp;
      #1;
      pop = o_valid & ~st;
      if (!in_run) chk("m_reset_valid", 32'(o_valid), 32'h0);
      if (ev == 1 || ev == 2) chk("m_bubble_valid", 32'(o_valid), 32'h0);
      if (ev >= 3) chk("m_stream_valid", 32'(o_valid), 32'h1);
      if (o_valid) begin
        chk("m_pc", o_pc, exp_pc);
        chk("m_inst", o_inst, memw(exp_pc));
      end else begin
        chk("m_idle_inst", o_inst, INST_NOP);
      end
      exp_req = in_run && !rd && ((out - (pop ? 1 : 0)) < 2);
      chk("m_req", 32'(imem_req), 32'(exp_req));
      chk("m_addr", imem_addr, exp_fetch);
`ifdef RV32I_FETCH_PERF_EN
      chk("m_fetch_cnt", fetch_cnt, m_fetch);
      chk("m_flush_cnt", flush_cnt, m_flush);
      m_fetch = m_fetch + 32'(exp_req);
      m_flush = m_flush + 32'(rd && in_run);
`endif
      if (rd) begin
        exp_pc    = rp & 32'hFFFF_FFFC;
        exp_fetch = rp & 32'hFFFF_FFFC;
        out       = 0;
        ev        = 1;
      end else begin
        if (pop) begin
          exp_pc = exp_pc + 32'd4;
          out--;
        end
        if (exp_req) begin
          exp_fetch = exp_fetch + 32'd4;
          out++;
        end
        if (ev < 3) ev++;
      end
      in_run = 1'b1;
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    //          stall redir rpc       valid pc        req addr
    tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[2]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 1'b1, 32'h04};
    tbl[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 1'b1, 32'h08};
    tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04, 1'b1, 32'h0C};
    tbl[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 1'b0, 32'h10};
    tbl[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 1'b0, 32'h10};
    tbl[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 1'b0, 32'h10};
    tbl[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 1'b0, 32'h10};
    tbl[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08, 1'b0, 32'h10};
    tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08, 1'b1, 32'h10};
    tbl[11] = '{1'b0, 1'b1, 32'h40, 1'b1, 32'h0C, 1'b0, 32'h14};
    tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0C, 1'b1, 32'h40};
    tbl[13] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0C, 1'b1, 32'h44};
    tbl[14] = '{1'b1, 1'b1, 32'h42, 1'b1, 32'h40, 1'b0, 32'h48};
    tbl[15] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h40, 1'b1, 32'h40};
    tbl[16] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h40, 1'b1, 32'h44};
    tbl[17] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h40, 1'b1, 32'h48};
    tbl[18] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h44, 1'b1, 32'h4C};

    repeat (3) @(posedge clk);

    // Directed timeline; row 0 is the idle cycle right after reset release
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) rst = 1'b1;
      stall = tbl[i].stall; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_pc", i), o_pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_inst", i), o_inst,
          tbl[i].exp_valid ? memw(tbl[i].exp_pc) : INST_NOP);
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
    end

    // Fill the buffer under stall, then reset mid-stream
    stall = 1'b1; redirect = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #1;
    chk("full_valid", 32'(o_valid), 32'h1);
    chk("full_req", 32'(imem_req), 32'h0);
    async_reset_check();

    // Restart from RESET_PC, then random traffic
    run_model(1500, 1'b0, 32'h0);

    // Redirect landing in the idle reset cycle
    async_reset_check();
    run_model(300, 1'b1, 32'h0000_0082);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
